regfile_wr_arbiter: RTL and testbench

- Controller that owns the single write port (we3/wa3/wd3) of the 8-entry register file and shares it between two write requesters: port 0 (core writeback) and port 1 (load/IO path).
- Uses round-robin arbitration with a valid/ready handshake.
- Provides a clear sequencer that zeroes registers 1..7 on request.
- Enforces the read-only $0 rule by dropping writes to address 0.

---
 rtl/regfile_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Round-robin owner of the register-file write port with a clear walk over registers 1..NREG-1 and $0 write dropping.
// Writes land one cycle after acceptance; ready is combinational and held low during reset, clear and the done cycle.
module regfile_wr_arbiter #(
    parameter int N    = 8,
    parameter int AW   = 3,
    parameter int NREG = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [N-1:0]  req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [N-1:0]  req1_data,
    output logic          req1_ready,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          zero_drop,
    output logic          rf_we3,
    output logic [AW-1:0] rf_wa3,
    output logic [N-1:0]  rf_wd3
);

    localparam logic [1:0]    IDLE     = 2'd0;
    localparam logic [1:0]    CLEAR    = 2'd1;
    localparam logic [1:0]    DONE     = 2'd2;
    localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

    logic [1:0]    state_q, state_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [N-1:0]  wd_q, wd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          zd_q, zd_d;
    logic          arb_en;
    logic          grant0, grant1;
    logic [AW-1:0] sel_addr;
    logic [N-1:0]  sel_data;

    // last_q=1 means port 1 won most recently, so port 0 is favoured next
    always_comb begin
        arb_en = (state_q == IDLE) && !clr_req && !rst;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (arb_en) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_q;
                grant1 = !last_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign sel_addr   = grant1 ? req1_addr : req0_addr;
    assign sel_data   = grant1 ? req1_data : req0_data;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        zd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    we_d    = 1'b1;
                    wa_d    = AW'(1);
                    wd_d    = '0;
                    busy_d  = 1'b1;
                end else if (grant0 || grant1) begin
                    last_d = grant1;
                    wa_d   = sel_addr;
                    wd_d   = sel_data;
                    we_d   = (sel_addr != '0);
                    zd_d   = (sel_addr == '0);
                end
            end
            CLEAR: begin
                if (wa_q == LAST_REG) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    we_d = 1'b1;
                    wa_d = wa_q + AW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            zd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            zd_q    <= zd_d;
        end
    end

    assign rf_we3    = we_q;
    assign rf_wa3    = wa_q;
    assign rf_wd3    = wd_q;
    assign clr_busy  = busy_q;
    assign clr_done  = done_q;
    assign zero_drop = zd_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench: each cycle checks ready against the stated grant and registered outputs against a queued expectation.
module tb_regfile_wr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid, clr_req;
    logic [2:0] req0_addr, req1_addr;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic       clr_busy, clr_done, zero_drop;
    logic       rf_we3;
    logic [2:0] rf_wa3;
    logic [7:0] rf_wd3;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.N(8), .AW(3), .NREG(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .zero_drop(zero_drop),
        .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3)
    );

    typedef struct packed {
        logic       we;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       zd;
        logic       busy;
        logic       done;
    } out_t;

    out_t       sb_q[$];
    logic [2:0] hold_wa = 3'd0;
    logic [7:0] hold_wd = 8'd0;
    int         checks  = 0;
    int         errors  = 0;

    function out_t exp_write(input logic [2:0] a, input logic [7:0] d);
        hold_wa = a;
        hold_wd = d;
        return '{we: (a != 3'd0), wa: a, wd: d, zd: (a == 3'd0), busy: 1'b0, done: 1'b0};
    endfunction

    function out_t exp_idle();
        return '{we: 1'b0, wa: hold_wa, wd: hold_wd, zd: 1'b0, busy: 1'b0, done: 1'b0};
    endfunction

    function out_t exp_clr(input logic [2:0] a);
        hold_wa = a;
        hold_wd = 8'd0;
        return '{we: 1'b1, wa: a, wd: 8'd0, zd: 1'b0, busy: 1'b1, done: 1'b0};
    endfunction

    function out_t exp_done();
        return '{we: 1'b0, wa: hold_wa, wd: hold_wd, zd: 1'b0, busy: 1'b1, done: 1'b1};
    endfunction

    function out_t exp_reset();
        hold_wa = 3'd0;
        hold_wd = 8'd0;
        return '{we: 1'b0, wa: 3'd0, wd: 8'd0, zd: 1'b0, busy: 1'b0, done: 1'b0};
    endfunction

    // One cycle: inputs already driven; check ready now, check outputs queued for this cycle, queue next cycle's.
    task automatic cyc(input string tag, input logic e0, input logic e1, input out_t nxt);
        out_t obs;
        out_t exp;
        @(negedge clk);
        checks++;
        assert (req0_ready === e0)
        else begin
            errors++;
            $error("FAIL %s ready0 obs=%b exp=%b", tag, req0_ready, e0);
        end
        checks++;
        assert (req1_ready === e1)
        else begin
            errors++;
            $error("FAIL %s ready1 obs=%b exp=%b", tag, req1_ready, e1);
        end
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            obs = '{we: rf_we3, wa: rf_wa3, wd: rf_wd3, zd: zero_drop, busy: clr_busy, done: clr_done};
            checks++;
            assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s outputs obs we=%b wa=%0d wd=%h zd=%b busy=%b done=%b exp we=%b wa=%0d wd=%h zd=%b busy=%b done=%b",
                       tag, obs.we, obs.wa, obs.wd, obs.zd, obs.busy, obs.done,
                       exp.we, exp.wa, exp.wd, exp.zd, exp.busy, exp.done);
            end
        end
        sb_q.push_back(nxt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 3'd1;
        req0_data  = 8'h11;
        req1_valid = 1'b0;
        req1_addr  = 3'd0;
        req1_data  = 8'h00;
        clr_req    = 1'b0;

        // Reset with a pending request: no grant, outputs cleared
        cyc("reset", 1'b0, 1'b0, exp_reset());
        cyc("reset", 1'b0, 1'b0, exp_reset());

        // Single write
        rst = 1'b0; req0_addr = 3'd1; req0_data = 8'hAB;
        cyc("single", 1'b1, 1'b0, exp_write(3'd1, 8'hAB));
        req0_valid = 1'b0;
        cyc("single_wr", 1'b0, 1'b0, exp_idle());

        // Fresh reset so port 0 is favoured, then contention
        rst = 1'b1;
        cyc("reset2", 1'b0, 1'b0, exp_reset());
        rst = 1'b0;
        req0_valid = 1'b1; req0_addr = 3'd4; req0_data = 8'hFF;
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 8'hAF;
        cyc("rr0", 1'b1, 1'b0, exp_write(3'd4, 8'hFF));
        cyc("rr1", 1'b0, 1'b1, exp_write(3'd5, 8'hAF));
        cyc("rr2", 1'b1, 1'b0, exp_write(3'd4, 8'hFF));
        cyc("rr3", 1'b0, 1'b1, exp_write(3'd5, 8'hAF));

        // Write to $0 is accepted but dropped
        req0_valid = 1'b0;
        req1_addr = 3'd0; req1_data = 8'h55;
        cyc("zero", 1'b0, 1'b1, exp_write(3'd0, 8'h55));
        req1_valid = 1'b0;
        cyc("zero_drop", 1'b0, 1'b0, exp_idle());

        // Clear while req0 pending; clr_req held high through the walk is ignored
        req0_valid = 1'b1; req0_addr = 3'd2; req0_data = 8'h3C;
        clr_req = 1'b1;
        cyc("clr_start", 1'b0, 1'b0, exp_clr(3'd1));
        for (int k = 2; k <= 7; k++) cyc("clr_walk", 1'b0, 1'b0, exp_clr(3'(k)));
        cyc("clr_last", 1'b0, 1'b0, exp_done());
        clr_req = 1'b0;
        cyc("clr_done", 1'b0, 1'b0, exp_idle());
        cyc("post_clr", 1'b1, 1'b0, exp_write(3'd2, 8'h3C));
        req0_valid = 1'b0;
        cyc("post_clr_wr", 1'b0, 1'b0, exp_idle());

        // Reset during the rf_wa3=3 cycle aborts the walk without a done pulse
        clr_req = 1'b1;
        cyc("clr2_start", 1'b0, 1'b0, exp_clr(3'd1));
        clr_req = 1'b0;
        cyc("clr2_wa1", 1'b0, 1'b0, exp_clr(3'd2));
        cyc("clr2_wa2", 1'b0, 1'b0, exp_clr(3'd3));
        rst = 1'b1;
        cyc("clr2_rst", 1'b0, 1'b0, exp_reset());
        rst = 1'b0;
        cyc("abort", 1'b0, 1'b0, exp_idle());
        cyc("abort_idle", 1'b0, 1'b0, exp_idle());

        // Arbiter still serves port 1 after the aborted walk
        req1_valid = 1'b1; req1_addr = 3'd7; req1_data = 8'h5A;
        cyc("after_abort", 1'b0, 1'b1, exp_write(3'd7, 8'h5A));
        req1_valid = 1'b0;
        cyc("after_abort_wr", 1'b0, 1'b0, exp_idle());
        cyc("final", 1'b0, 1'b0, exp_idle());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
